// File: rtl/vending_dispense_arbiter.sv
// Two-panel vending controller: per-panel coin/credit/selection handling and a
// round-robin scheduler that shares one dispenser between panels A and B.
module vending_dispense_arbiter #(
   parameter int PRICE_WATER    = 30,
   parameter int PRICE_SODA     = 50,
   parameter int PRICE_JUICE    = 70,
   parameter int DELIVER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] coin_a,
   input  logic [7:0] coin_b,
   input  logic [1:0] button_a,
   input  logic [1:0] button_b,
   input  logic       refund_a,
   input  logic       refund_b,
   output logic [7:0] credit_a,
   output logic [7:0] credit_b,
   output logic [7:0] change_a,
   output logic [7:0] change_b,
   output logic       reject_a,
   output logic       reject_b,
   output logic [1:0] beverage_out,
   output logic       served_b,
   output logic       busy
);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_DELIVER = 1'b1;

   // Sized so that DELIVER_CYCLES-1 always fits, including DELIVER_CYCLES == 1.
   localparam int CNT_W = $clog2(DELIVER_CYCLES + 1);

   // Accepted coin denominations; anything else is handed straight back.
   function automatic logic coin_ok(input logic [7:0] v);
      case (v)
         8'd10, 8'd20, 8'd50, 8'd100, 8'd200: coin_ok = 1'b1;
         default:                             coin_ok = 1'b0;
      endcase
   endfunction

   // Price lookup for a selection code; code 0 never reaches a comparison.
   function automatic logic [7:0] price_of(input logic [1:0] sel);
      case (sel)
         2'd1:    price_of = 8'(PRICE_WATER);
         2'd2:    price_of = 8'(PRICE_SODA);
         2'd3:    price_of = 8'(PRICE_JUICE);
         default: price_of = 8'd0;
      endcase
   endfunction

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             last_b;

   logic             pend_a, pend_b;
   logic [1:0]       sel_a, sel_b;

   logic             grant_a, grant_b;
   logic             lock_a, lock_b;
   logic [8:0]       sum_a, sum_b;

   logic [7:0]       credit_a_nxt, credit_b_nxt;
   logic [7:0]       change_a_nxt, change_b_nxt;
   logic             reject_a_nxt, reject_b_nxt;
   logic             pend_a_nxt, pend_b_nxt;
   logic [1:0]       sel_a_nxt, sel_b_nxt;

   assign busy = (state == S_DELIVER);

   // A panel stays locked from the accepted press until its own delivery ends.
   assign lock_a = pend_a | (busy & ~served_b);
   assign lock_b = pend_b | (busy &  served_b);

   // Nine-bit sums expose the overflow that makes a coin unacceptable.
   assign sum_a = {1'b0, credit_a} + {1'b0, coin_a};
   assign sum_b = {1'b0, credit_b} + {1'b0, coin_b};

   // Round-robin grant: on a tie the panel that was not served last wins.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == S_IDLE) begin
         if (pend_a && pend_b) begin
            grant_a = last_b;
            grant_b = ~last_b;
         end else begin
            grant_a = pend_a;
            grant_b = pend_b;
         end
      end
   end

   // Panel A: grant settlement, refund, coin acceptance and selection capture.
   always_comb begin
      credit_a_nxt = credit_a;
      change_a_nxt = 8'd0;
      reject_a_nxt = 1'b0;
      pend_a_nxt   = pend_a;
      sel_a_nxt    = sel_a;
      if (grant_a) begin
         // Grant implies credit >= price, so the subtraction cannot wrap.
         credit_a_nxt = 8'd0;
         change_a_nxt = credit_a - price_of(sel_a);
         pend_a_nxt   = 1'b0;
         reject_a_nxt = (coin_a != 8'd0);
      end else if (lock_a) begin
         reject_a_nxt = (coin_a != 8'd0);
      end else if (refund_a) begin
         credit_a_nxt = 8'd0;
         change_a_nxt = credit_a;
         reject_a_nxt = (coin_a != 8'd0);
      end else begin
         if (coin_a != 8'd0) begin
            if (coin_ok(coin_a) && !sum_a[8]) begin
               credit_a_nxt = sum_a[7:0];
            end else begin
               reject_a_nxt = 1'b1;
            end
         end
         // Affordability uses the credit held before any same-cycle coin.
         if ((button_a != 2'd0) && (credit_a >= price_of(button_a))) begin
            pend_a_nxt = 1'b1;
            sel_a_nxt  = button_a;
         end
      end
   end

   // Panel B: same behaviour as panel A.
   always_comb begin
      credit_b_nxt = credit_b;
      change_b_nxt = 8'd0;
      reject_b_nxt = 1'b0;
      pend_b_nxt   = pend_b;
      sel_b_nxt    = sel_b;
      if (grant_b) begin
         credit_b_nxt = 8'd0;
         change_b_nxt = credit_b - price_of(sel_b);
         pend_b_nxt   = 1'b0;
         reject_b_nxt = (coin_b != 8'd0);
      end else if (lock_b) begin
         reject_b_nxt = (coin_b != 8'd0);
      end else if (refund_b) begin
         credit_b_nxt = 8'd0;
         change_b_nxt = credit_b;
         reject_b_nxt = (coin_b != 8'd0);
      end else begin
         if (coin_b != 8'd0) begin
            if (coin_ok(coin_b) && !sum_b[8]) begin
               credit_b_nxt = sum_b[7:0];
            end else begin
               reject_b_nxt = 1'b1;
            end
         end
         if ((button_b != 2'd0) && (credit_b >= price_of(button_b))) begin
            pend_b_nxt = 1'b1;
            sel_b_nxt  = button_b;
         end
      end
   end

   // Panel A registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_a <= 8'd0;
         change_a <= 8'd0;
         reject_a <= 1'b0;
         pend_a   <= 1'b0;
         sel_a    <= 2'd0;
      end else begin
         credit_a <= credit_a_nxt;
         change_a <= change_a_nxt;
         reject_a <= reject_a_nxt;
         pend_a   <= pend_a_nxt;
         sel_a    <= sel_a_nxt;
      end
   end

   // Panel B registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_b <= 8'd0;
         change_b <= 8'd0;
         reject_b <= 1'b0;
         pend_b   <= 1'b0;
         sel_b    <= 2'd0;
      end else begin
         credit_b <= credit_b_nxt;
         change_b <= change_b_nxt;
         reject_b <= reject_b_nxt;
         pend_b   <= pend_b_nxt;
         sel_b    <= sel_b_nxt;
      end
   end

   // Scheduler: IDLE grants a pending panel, DELIVER holds the dispenser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         last_b       <= 1'b1;
         beverage_out <= 2'd0;
         served_b     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_a || grant_b) begin
                  state        <= S_DELIVER;
                  cnt          <= CNT_W'(DELIVER_CYCLES - 1);
                  beverage_out <= grant_b ? sel_b : sel_a;
                  served_b     <= grant_b;
                  last_b       <= grant_b;
               end
            end
            S_DELIVER: begin
               // Returning to IDLE here guarantees an idle cycle between deliveries.
               if (cnt == '0) begin
                  state        <= S_IDLE;
                  beverage_out <= 2'd0;
                  served_b     <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state        <= S_IDLE;
               beverage_out <= 2'd0;
               served_b     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vending_dispense_arbiter.sv
// Directed bench for vending_dispense_arbiter with a delivery scoreboard.
module tb_vending_dispense_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] coin_a, coin_b;
   logic [1:0] button_a, button_b;
   logic       refund_a, refund_b;
   logic [7:0] credit_a, credit_b, change_a, change_b;
   logic       reject_a, reject_b;
   logic [1:0] beverage_out;
   logic       served_b, busy;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   typedef struct {
      logic       b;
      logic [1:0] sel;
      logic [7:0] chg;
      int         start;
   } exp_t;

   exp_t exp_q[$];

   vending_dispense_arbiter #(
      .PRICE_WATER(30), .PRICE_SODA(50), .PRICE_JUICE(70), .DELIVER_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .coin_a(coin_a), .coin_b(coin_b),
      .button_a(button_a), .button_b(button_b),
      .refund_a(refund_a), .refund_b(refund_b),
      .credit_a(credit_a), .credit_b(credit_b),
      .change_a(change_a), .change_b(change_b),
      .reject_a(reject_a), .reject_b(reject_b),
      .beverage_out(beverage_out), .served_b(served_b), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      coin_a = 8'd0; coin_b = 8'd0;
      button_a = 2'd0; button_b = 2'd0;
      refund_a = 1'b0; refund_b = 1'b0;
   endtask

   // Delivery monitor: pops the scoreboard on each delivery start and checks length.
   logic [1:0] prev_bev;
   int         run_len;
   always @(negedge clk) begin
      if (rst) begin
         prev_bev = 2'd0;
         run_len  = 0;
      end else begin
         if (beverage_out != 2'd0 && prev_bev == 2'd0) begin
            chk("unexpected_delivery", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("dlv_sel",    32'(beverage_out), 32'(e.sel));
               chk("dlv_served", 32'(served_b), 32'(e.b));
               chk("dlv_change", 32'(e.b ? change_b : change_a), 32'(e.chg));
               chk("dlv_credit", 32'(e.b ? credit_b : credit_a), 32'd0);
               chk("dlv_start",  32'(cyc), 32'(e.start));
               chk("dlv_busy",   32'(busy), 32'd1);
            end
            run_len = 1;
         end else if (beverage_out != 2'd0) begin
            run_len++;
         end else if (prev_bev != 2'd0) begin
            chk("dlv_length", 32'(run_len), 32'd4);
         end
         prev_bev = beverage_out;
      end
   end

   initial begin
      rst = 1'b1;
      idle_in();
      prev_bev = 2'd0;
      run_len  = 0;
      tick(); tick();
      // Reset values
      chk("rst_credit_a", 32'(credit_a), 32'd0);
      chk("rst_credit_b", 32'(credit_b), 32'd0);
      chk("rst_change_a", 32'(change_a), 32'd0);
      chk("rst_change_b", 32'(change_b), 32'd0);
      chk("rst_reject",   32'({reject_a, reject_b}), 32'd0);
      chk("rst_bev",      32'(beverage_out), 32'd0);
      chk("rst_served",   32'(served_b), 32'd0);
      chk("rst_busy",     32'(busy), 32'd0);
      rst = 1'b0;
      tick();

      // First tie: A wins, B follows DELIVER_CYCLES+1 later
      coin_a = 8'd100; coin_b = 8'd100; tick(); idle_in();
      chk("tie1_credit_a", 32'(credit_a), 32'd100);
      chk("tie1_credit_b", 32'(credit_b), 32'd100);
      button_a = 2'd2; button_b = 2'd2; tick(); idle_in();
      exp_q.push_back('{1'b0, 2'd2, 8'd50, cyc + 1});
      exp_q.push_back('{1'b1, 2'd2, 8'd50, cyc + 6});
      repeat (3) tick();
      chk("tie1_busy",        32'(busy), 32'd1);
      chk("tie1_b_held",      32'(credit_b), 32'd100);
      repeat (11) tick();
      chk("tie1_drained",     32'(exp_q.size()), 32'd0);
      chk("tie1_credit_b0",   32'(credit_b), 32'd0);
      chk("tie1_idle",        32'(busy), 32'd0);

      // Panel A solo purchase with exact payment
      coin_a = 8'd20; tick(); idle_in();
      chk("t1_credit20", 32'(credit_a), 32'd20);
      coin_a = 8'd10; tick(); idle_in();
      chk("t1_credit30", 32'(credit_a), 32'd30);
      button_a = 2'd1; tick(); idle_in();
      exp_q.push_back('{1'b0, 2'd1, 8'd0, cyc + 1});
      chk("t1_credit_pending", 32'(credit_a), 32'd30);
      repeat (7) tick();
      chk("t1_drained",  32'(exp_q.size()), 32'd0);
      chk("t1_credit0",  32'(credit_a), 32'd0);
      chk("t1_idle",     32'(busy), 32'd0);

      // Second tie after A was served last: B wins
      coin_a = 8'd100; coin_b = 8'd100; tick(); idle_in();
      button_a = 2'd1; button_b = 2'd1; tick(); idle_in();
      exp_q.push_back('{1'b1, 2'd1, 8'd70, cyc + 1});
      exp_q.push_back('{1'b0, 2'd1, 8'd70, cyc + 6});
      repeat (14) tick();
      chk("tie2_drained", 32'(exp_q.size()), 32'd0);

      // Coin acceptance boundaries on panel A
      coin_a = 8'd15; tick(); idle_in();
      chk("t2_rej15",      32'(reject_a), 32'd1);
      chk("t2_credit_un",  32'(credit_a), 32'd0);
      tick();
      chk("t2_rej_pulse",  32'(reject_a), 32'd0);
      coin_a = 8'd200; tick(); idle_in();
      coin_a = 8'd50;  tick(); idle_in();
      chk("t2_credit250",  32'(credit_a), 32'd250);
      chk("t2_no_rej",     32'(reject_a), 32'd0);
      coin_a = 8'd10; tick(); idle_in();
      chk("t2_rej_ovf",    32'(reject_a), 32'd1);
      chk("t2_credit_ovf", 32'(credit_a), 32'd250);
      refund_a = 1'b1; tick(); idle_in();
      chk("t2_refund",     32'(change_a), 32'd250);
      chk("t2_refund_cr",  32'(credit_a), 32'd0);
      tick();
      chk("t2_change_pulse", 32'(change_a), 32'd0);

      // Insufficient credit press ignored, refund beats a same-cycle coin
      coin_b = 8'd20; tick(); idle_in();
      button_b = 2'd3; tick(); idle_in();
      tick();
      chk("t4_no_grant",   32'(busy), 32'd0);
      chk("t4_no_bev",     32'(beverage_out), 32'd0);
      chk("t4_credit",     32'(credit_b), 32'd20);
      refund_b = 1'b1; coin_b = 8'd10; tick(); idle_in();
      chk("t4_change",     32'(change_b), 32'd20);
      chk("t4_credit0",    32'(credit_b), 32'd0);
      chk("t4_coin_rej",   32'(reject_b), 32'd1);
      tick();
      chk("t4_change_end", 32'(change_b), 32'd0);
      chk("t4_rej_end",    32'(reject_b), 32'd0);

      // Coins during A's delivery: A locked, B still accepts
      coin_a = 8'd50; tick(); idle_in();
      button_a = 2'd1; tick(); idle_in();
      exp_q.push_back('{1'b0, 2'd1, 8'd20, cyc + 1});
      tick();
      chk("t5_busy", 32'(busy), 32'd1);
      coin_a = 8'd50; coin_b = 8'd50; button_a = 2'd2; tick(); idle_in();
      chk("t5_rej_a",    32'(reject_a), 32'd1);
      chk("t5_credit_a", 32'(credit_a), 32'd0);
      chk("t5_credit_b", 32'(credit_b), 32'd50);
      chk("t5_rej_b",    32'(reject_b), 32'd0);
      repeat (6) tick();
      chk("t5_drained",  32'(exp_q.size()), 32'd0);
      chk("t5_idle",     32'(busy), 32'd0);
      refund_b = 1'b1; tick(); idle_in();
      chk("t5_refund_b", 32'(change_b), 32'd50);

      // Reset during the second DELIVER cycle
      coin_a = 8'd50; coin_b = 8'd100; tick(); idle_in();
      button_a = 2'd1; tick(); idle_in();
      exp_q.push_back('{1'b0, 2'd1, 8'd20, cyc + 1});
      tick(); tick();
      chk("t6_delivering", 32'(beverage_out), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_bev0",    32'(beverage_out), 32'd0);
      chk("t6_busy0",   32'(busy), 32'd0);
      chk("t6_credit_b0", 32'(credit_b), 32'd0);
      chk("t6_outs0",   32'({change_a, change_b, reject_a, reject_b, served_b}), 32'd0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("t6_credit_a", 32'(credit_a), 32'd0);
      chk("t6_no_pend",  32'(busy), 32'd0);
      chk("t6_no_bev",   32'(beverage_out), 32'd0);
      chk("t6_drained",  32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
